// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
// Holds the parity mode codes, FSM state encoding, the minimum bit period
// and the layout of a completed-frame entry {break, ferr, perr, data}.
package uart_pkg;

  // Parity mode codes as seen on cfg_parity (2'b11 behaves as none)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  // Smallest bit period the sampler supports
  localparam int unsigned CPB_MIN = 4;

  // Status bit offsets above the data field inside a frame entry
  localparam int unsigned ENT_PERR_OFS    = 0;
  localparam int unsigned ENT_FERR_OFS    = 1;
  localparam int unsigned ENT_BRK_OFS     = 2;
  localparam int unsigned ENT_STATUS_BITS = 3;

  // True when the mode carries a parity bit
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Valid/ready frame stream from the UART receiver to the bus-side wrapper.
//   master: rx_valid, rx_data, rx_perr, rx_ferr, rx_break, rx_overrun out; rx_ready in
//   slave : the reverse
interface uart_rx_cfg_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    rx_valid;
  logic                    rx_ready;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    rx_perr;
  logic                    rx_ferr;
  logic                    rx_break;
  logic                    rx_overrun;

  modport master (
    output rx_valid, rx_data, rx_perr, rx_ferr, rx_break, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, rx_perr, rx_ferr, rx_break, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO, head presented combinationally on o_dout.
//   clk, resetn (sync, active low)
//   i_push/i_din : write side; a push while full is accepted only with a pop
//   i_pop        : read side; ignored while empty
//   o_dout, o_full, o_empty
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer MSB distinguishes full from empty
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: parity none/even/odd, 1 or 2 stop
// bits, false-start rejection, parity/framing/break status and overrun.
//   clk, resetn           : clock, synchronous active-low reset
//   uart_rxd, uart_rx_en  : serial line and receive enable
//   cfg_cycles_per_bit, cfg_parity, cfg_stop2 : latched at each start edge
//   rx_if (master)        : valid/ready frame stream with status flags
// Build option UART_RX_FIFO_EN: completed frames go through a FIFO_DEPTH
// entry FIFO instead of the single output register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS  = 8,
  parameter int unsigned COUNT_REG_LEN = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     uart_rxd,
  input  logic                     uart_rx_en,
  input  logic [COUNT_REG_LEN-1:0] cfg_cycles_per_bit,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  uart_rx_cfg_if.master            rx_if
);

  localparam int unsigned PB        = PAYLOAD_BITS;
  localparam int unsigned CW        = COUNT_REG_LEN;
  localparam int unsigned BIT_CNT_W = $clog2(PAYLOAD_BITS + 1);
  localparam int unsigned ENT_W     = PAYLOAD_BITS + ENT_STATUS_BITS;

  if ((PAYLOAD_BITS < 5) || (PAYLOAD_BITS > 9) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("uart_rx_cfg: PAYLOAD_BITS must be 5..9, FIFO_DEPTH a power of 2 >= 2");
  end

  logic                 r_rxd_s1;
  logic                 r_rxd_s2;
  rx_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_cpb;
  logic [1:0]           r_par;
  logic                 r_stop2;
  logic [PB-1:0]        r_data;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_pbit;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_stop_idx;
  logic                 r_stop1;
  logic                 r_overrun;

  logic                 w_line;
  logic [CW-1:0]        w_cpb_clamped;
  logic                 w_sample;
  logic                 w_half;
  logic                 w_last_stop;
  logic                 w_done;
  logic                 w_first_stop;
  logic                 w_ferr;
  logic                 w_brk;
  logic [ENT_W-1:0]     w_entry;

  assign w_line        = r_rxd_s2;
  assign w_cpb_clamped = (cfg_cycles_per_bit < CW'(CPB_MIN)) ? CW'(CPB_MIN) : cfg_cycles_per_bit;
  assign w_sample      = (r_cnt == (r_cpb - CW'(1)));
  assign w_half        = (r_cnt == (r_cpb >> 1));
  assign w_last_stop   = !r_stop2 || r_stop_idx;
  assign w_done        = uart_rx_en && (r_state == ST_STOP) && w_sample && w_last_stop;
  // On the second stop sample the first stop value comes from its register
  assign w_first_stop  = r_stop_idx ? r_stop1 : w_line;
  assign w_ferr        = r_ferr | ~w_line;
  assign w_brk         = (r_data == '0) && !(par_enabled(r_par) && r_pbit) && !w_first_stop;

  // Completed-frame entry {break, ferr, perr, data}
  always_comb begin
    w_entry                     = '0;
    w_entry[PB-1:0]             = r_data;
    w_entry[PB + ENT_PERR_OFS]  = r_perr;
    w_entry[PB + ENT_FERR_OFS]  = w_ferr;
    w_entry[PB + ENT_BRK_OFS]   = w_brk;
  end

  // Synchroniser and receive FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cpb      <= CW'(CPB_MIN);
      r_par      <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_stop1    <= 1'b1;
    end else if (!uart_rx_en) begin
      // Synchroniser holds; any frame in progress is abandoned
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_line) begin
            r_state <= ST_START;
            r_cpb   <= w_cpb_clamped;
            r_par   <= cfg_parity;
            r_stop2 <= cfg_stop2;
          end
        end
        ST_START: begin
          // Re-check the line at mid start bit to reject glitches
          if (w_half) begin
            r_cnt <= '0;
            if (w_line) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_cnt  <= '0;
            r_data <= {w_line, r_data[PB-1:1]};
            if (r_bit_cnt == BIT_CNT_W'(PAYLOAD_BITS - 1)) begin
              r_state    <= par_enabled(r_par) ? ST_PARITY : ST_STOP;
              r_perr     <= 1'b0;
              r_pbit     <= 1'b0;
              r_ferr     <= 1'b0;
              r_stop_idx <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            r_cnt   <= '0;
            r_pbit  <= w_line;
            r_perr  <= ((^r_data) ^ w_line) != (r_par == PAR_ODD);
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            r_cnt <= '0;
            if (w_last_stop) begin
              // Leave mid stop bit so the next start edge is caught
              r_state <= w_brk ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
              r_stop1    <= w_line;
              r_ferr     <= w_ferr;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_BRK_WAIT: begin
          r_cnt <= '0;
          if (w_line) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [ENT_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_pop = !w_empty && rx_if.rx_ready;

  uart_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_done),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Overrun only when full and nothing leaves in the same cycle
  always_ff @(posedge clk) begin
    if (!resetn) r_overrun <= 1'b0;
    else         r_overrun <= w_done && w_full && !w_pop;
  end

  assign rx_if.rx_valid   = !w_empty;
  assign rx_if.rx_data    = w_head[PB-1:0];
  assign rx_if.rx_perr    = w_head[PB + ENT_PERR_OFS];
  assign rx_if.rx_ferr    = w_head[PB + ENT_FERR_OFS];
  assign rx_if.rx_break   = w_head[PB + ENT_BRK_OFS];
  assign rx_if.rx_overrun = r_overrun;
`else
  logic             r_out_valid;
  logic [ENT_W-1:0] r_out_entry;

  // Single-entry output register; a held entry is never overwritten
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_entry <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_out_valid || rx_if.rx_ready) begin
          r_out_valid <= 1'b1;
          r_out_entry <= w_entry;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && rx_if.rx_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_valid   = r_out_valid;
  assign rx_if.rx_data    = r_out_entry[PB-1:0];
  assign rx_if.rx_perr    = r_out_entry[PB + ENT_PERR_OFS];
  assign rx_if.rx_ferr    = r_out_entry[PB + ENT_FERR_OFS];
  assign rx_if.rx_break   = r_out_entry[PB + ENT_BRK_OFS];
  assign rx_if.rx_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed and random serial frames checked
// against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int unsigned PB = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          uart_rxd;
  logic          uart_rx_en;
  logic [CW-1:0] cfg_cpb;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;
  logic [10:0] got_q[$];

  uart_rx_cfg_if #(.PAYLOAD_BITS(PB)) rx_if ();

  uart_rx_cfg #(
    .PAYLOAD_BITS  (PB),
    .COUNT_REG_LEN (CW),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .uart_rxd           (uart_rxd),
    .uart_rx_en         (uart_rx_en),
    .cfg_cycles_per_bit (cfg_cpb),
    .cfg_parity         (cfg_parity),
    .cfg_stop2          (cfg_stop2),
    .rx_if              (rx_if)
  );

  always #5 clk = ~clk;

  // Collect accepted frames and overrun pulses
  always @(negedge clk) begin
    if (resetn && rx_if.rx_valid && rx_if.rx_ready)
      got_q.push_back({rx_if.rx_break, rx_if.rx_ferr, rx_if.rx_perr, rx_if.rx_data});
    if (resetn && rx_if.rx_overrun) ovr_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: expected {break, ferr, perr, data}
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] par,
                                        input logic pbit, input logic s1, input logic s2,
                                        input logic stop2);
    logic par_on;
    int   ones;
    logic perr;
    logic ferr;
    logic brk;
    par_on = (par == 2'b01) || (par == 2'b10);
    ones   = $countones(d) + int'(pbit);
    perr   = par_on && ((par == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    ferr   = !s1 || (stop2 && !s2);
    brk    = (d == 8'h00) && !(par_on && pbit) && !s1;
    return {brk, ferr, perr, brk ? 8'h00 : d};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int cfg_v, input int period,
                            input logic [1:0] par, input logic pbit, input logic s1,
                            input logic s2, input logic stop2, input bit scramble);
    logic bits [16];
    int   n;
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n = n + 1; end
    if (par == 2'b01 || par == 2'b10) begin bits[n] = pbit; n = n + 1; end
    bits[n] = s1; n = n + 1;
    if (stop2) begin bits[n] = s2; n = n + 1; end
    cfg_cpb    = CW'(cfg_v);
    cfg_parity = par;
    cfg_stop2  = stop2;
    for (int i = 0; i < n; i++) begin
      uart_rxd = bits[i];
      if (scramble && i == 2) begin
        cfg_cpb    = CW'($urandom_range(0, 40));
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
      end
      if (scramble && i == 6) begin
        cfg_cpb    = CW'(cfg_v);
        cfg_parity = par;
        cfg_stop2  = stop2;
      end
      tick(period);
    end
    uart_rxd = 1'b1;
    tick(2 * period);
  endtask

  task automatic expect_frame(input string tag, input logic [10:0] exp);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) chk(tag, 32'(got_q.pop_front()), 32'(exp));
  endtask

  task automatic chk_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_valid"},   32'(rx_if.rx_valid),   32'd0);
    chk({tag, "_data"},    32'(rx_if.rx_data),    32'd0);
    chk({tag, "_perr"},    32'(rx_if.rx_perr),    32'd0);
    chk({tag, "_ferr"},    32'(rx_if.rx_ferr),    32'd0);
    chk({tag, "_break"},   32'(rx_if.rx_break),   32'd0);
    chk({tag, "_overrun"}, 32'(rx_if.rx_overrun), 32'd0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  par;
    logic        pbit;
    logic        s1;
    logic        s2;
    logic        st2;
    int          cpb;

    resetn         = 1'b0;
    uart_rxd       = 1'b1;
    uart_rx_en     = 1'b1;
    cfg_cpb        = CW'(16);
    cfg_parity     = 2'b00;
    cfg_stop2      = 1'b0;
    rx_if.rx_ready = 1'b1;
    tick(3);
    chk_outputs_zero("reset");
    resetn = 1'b1;
    tick(5);

    // Plain 8N1
    send_frame(8'h55, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("8n1_55", model(8'h55, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("8n1_single", 32'(got_q.size()), 32'd0);

    // Even parity, wrong then right parity bit
    send_frame(8'hA3, 16, 16, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("even_bad", 11'h1A3);
    send_frame(8'hA3, 16, 16, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("even_good", model(8'hA3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0));

    // Two stop bits, second one low
    send_frame(8'h3C, 16, 16, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_frame("stop2_ferr", 11'h23C);

    // Break: line low for 12 bit times
    cfg_cpb = CW'(16); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    uart_rxd = 1'b0;
    tick(12 * 16);
    uart_rxd = 1'b1;
    tick(64);
    expect_frame("break", 11'h600);
    chk("break_once", 32'(got_q.size()), 32'd0);
    send_frame(8'h7E, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("after_break", 11'h07E);

    // Short low glitch is rejected
    uart_rxd = 1'b0;
    tick(5);
    uart_rxd = 1'b1;
    tick(60);
    chk("glitch_none", 32'(got_q.size()), 32'd0);
    chk("glitch_valid", 32'(rx_if.rx_valid), 32'd0);
    send_frame(8'h81, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("after_glitch", 11'h081);

    // Bit period below minimum runs at the minimum
    send_frame(8'hC6, 2, 4, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("clamp", model(8'hC6, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0));

    // Random frames with mid-frame config disturbance
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      if (k % 8 == 3) d = 8'h00;
      par  = 2'($urandom);
      pbit = 1'($urandom);
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      st2  = 1'($urandom);
      cpb  = int'($urandom_range(8, 24));
      send_frame(d, cpb, cpb, par, pbit, s1, s2, st2, 1'b1);
      if (!s1 && d == 8'h00) tick(4);
      expect_frame($sformatf("rand%0d", k), model(d, par, pbit, s1, s2, st2));
      chk($sformatf("rand%0d_extra", k), 32'(got_q.size()), 32'd0);
    end
    chk("no_overrun_yet", 32'(ovr_cnt), 32'd0);

    // Consumer stalled across two frames
    rx_if.rx_ready = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h11, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_valid", 32'(rx_if.rx_valid), 32'd1);
    chk("stall_head", 32'(rx_if.rx_data), 32'h11);
`ifdef UART_RX_FIFO_EN
    chk("stall_overrun", 32'(ovr_cnt), 32'd0);
    rx_if.rx_ready = 1'b1;
    expect_frame("fifo_first", 11'h011);
    expect_frame("fifo_second", 11'h022);
`else
    chk("stall_overrun", 32'(ovr_cnt), 32'd1);
    rx_if.rx_ready = 1'b1;
    expect_frame("held_first", 11'h011);
    tick(10);
    chk("dropped_second", 32'(got_q.size()), 32'd0);
`endif

    // Reset in the middle of a frame with an entry pending
    rx_if.rx_ready = 1'b0;
    send_frame(8'h5A, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pending_valid", 32'(rx_if.rx_valid), 32'd1);
    tick(1);
    uart_rxd = 1'b0;
    tick(16 * 3);
    resetn = 1'b0;
    tick(1);
    chk_outputs_zero("midreset");
    uart_rxd = 1'b1;
    tick(2);
    resetn = 1'b1;
    rx_if.rx_ready = 1'b1;
    tick(40);
    chk("midreset_lost", 32'(got_q.size()), 32'd0);
    send_frame(8'h96, 16, 16, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("after_reset", model(8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0));

    // Receive disabled mid-frame discards it
    cfg_cpb = CW'(16); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    uart_rxd = 1'b0;
    tick(16 * 3);
    uart_rx_en = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(16 * 10);
    uart_rx_en = 1'b1;
    tick(40);
    chk("disable_none", 32'(got_q.size()), 32'd0);
    send_frame(8'h3A, 16, 16, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("after_disable", 11'h03A);
    chk("final_overrun", 32'(ovr_cnt), 32'(ovr_cnt_expected()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int ovr_cnt_expected();
`ifdef UART_RX_FIFO_EN
    return 0;
`else
    return 1;
`endif
  endfunction

endmodule
